// File: rtl/car_cmd_responder.sv
// Vehicle-side UART command receiver (8N1, header 2'b10) with detector reply transmitter.
// RX and TX run independently; a reply is queued one-deep while a frame is on the wire.
//
// rx state  | meaning
// RX_IDLE   | line idle, waiting for synchronized rxd low
// RX_START  | timing to mid start bit, rejects glitches
// RX_DATA   | sampling 8 data bits LSB first
// RX_STOP   | sampling the stop bit, issuing the result pulse
// RX_WAIT_HI| framing error seen, waiting for the line to return high
//
// tx state  | meaning
// TX_IDLE   | txd high, no reply in flight
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits LSB first
// TX_STOP   | driving the stop bit, chaining a pending reply at its end

module car_cmd_responder #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    input  logic [3:0] detector_in,
    output logic [5:0] cmd,
    output logic       cmd_valid,
    output logic       hdr_err,
    output logic       frame_err,
    output logic       tx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    rx_state_t     rx_state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic [7:0]    reply_byte;
    logic          pending;

    logic [7:0]    new_reply;
    logic          tx_done;

    assign new_reply = {4'b0000, detector_in};
    assign tx_done   = (tx_state == TX_STOP) && (tx_cnt == '0);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            hdr_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rx_sync   <= rx_meta;
            cmd_valid <= 1'b0;
            hdr_err   <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= BIT_LAST;
                            rx_idx   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= BIT_LAST;
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HI;
                        end else if (rx_shift[7:6] == 2'b10) begin
                            cmd       <= rx_shift[5:0];
                            cmd_valid <= 1'b1;
                            rx_state  <= RX_IDLE;
                        end else begin
                            hdr_err  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                RX_WAIT_HI: begin
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // The cmd_valid register doubles as the capture strobe for the reply byte.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            reply_byte <= '0;
            pending    <= 1'b0;
        end else begin
            if (cmd_valid) begin
                reply_byte <= new_reply;
            end
            if (cmd_valid && (tx_state != TX_IDLE) && !tx_done) begin
                pending <= 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (cmd_valid) begin
                        tx_shift <= new_reply;
                        txd      <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= '0;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        // A capture landing on the last stop cycle is the newest reply.
                        if (cmd_valid || pending) begin
                            tx_shift <= cmd_valid ? new_reply : reply_byte;
                            pending  <= 1'b0;
                            txd      <= 1'b0;
                            tx_cnt   <= BIT_LAST;
                            tx_state <= TX_START;
                        end else begin
                            tx_busy  <= 1'b0;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_cmd_responder.sv
// Bench for car_cmd_responder: directed and random command frames checked against an
// event-level model of RX results, reply frames and tx_busy run lengths.

module tb_car_cmd_responder;

    localparam int C      = 16;
    localparam int H      = C / 2;
    localparam int RX_LAT = 2 + H + 9 * C + 1;
    localparam int FRAME  = 10 * C;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       txd;
    logic [3:0] detector_in;
    logic [5:0] cmd;
    logic       cmd_valid;
    logic       hdr_err;
    logic       frame_err;
    logic       tx_busy;

    car_cmd_responder #(.CLKS_PER_BIT(C)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rxd        (rxd),
        .txd        (txd),
        .detector_in(detector_in),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .hdr_err    (hdr_err),
        .frame_err  (frame_err),
        .tx_busy    (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {int t; int kind; int cmd;} ev_t;
    typedef struct {int t; int data;} fr_t;

    ev_t obs_ev[$];
    ev_t exp_ev[$];
    fr_t obs_fr[$];
    fr_t exp_fr[$];
    int  obs_busy[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic ev_t mk_ev(int t, int kind, int c);
        ev_t e;
        e.t = t; e.kind = kind; e.cmd = c;
        return e;
    endfunction

    function automatic fr_t mk_fr(int t, int d);
        fr_t f;
        f.t = t; f.data = d;
        return f;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Result pulses as seen on the outputs: 1 = cmd_valid, 2 = hdr_err, 3 = frame_err.
    always @(negedge sys_clk) begin
        if (rst !== 1'b1) begin
            if (cmd_valid === 1'b1) obs_ev.push_back(mk_ev(cyc, 1, int'(cmd)));
            if (hdr_err === 1'b1)   obs_ev.push_back(mk_ev(cyc, 2, int'(cmd)));
            if (frame_err === 1'b1) obs_ev.push_back(mk_ev(cyc, 3, int'(cmd)));
        end
    end

    // UART decoder for txd: records start cycle and {stop, data}.
    logic       dec_active = 1'b0;
    int         dec_start  = 0;
    logic [7:0] dec_byte   = '0;
    always @(negedge sys_clk) begin
        if (rst === 1'b1) begin
            dec_active <= 1'b0;
        end else if (!dec_active) begin
            if (txd === 1'b0) begin
                dec_active <= 1'b1;
                dec_start  <= cyc;
            end
        end else if ((cyc - dec_start) > H && ((cyc - dec_start - H) % C) == 0) begin
            if ((cyc - dec_start - H) / C <= 8) begin
                dec_byte <= {txd, dec_byte[7:1]};
            end else begin
                obs_fr.push_back(mk_fr(dec_start, {23'b0, txd, dec_byte}));
                dec_active <= 1'b0;
            end
        end
    end

    int busy_len = 0;
    always @(negedge sys_clk) begin
        if (rst === 1'b1) begin
            busy_len <= 0;
        end else if (tx_busy === 1'b1) begin
            busy_len <= busy_len + 1;
        end else if (busy_len != 0) begin
            obs_busy.push_back(busy_len);
            busy_len <= 0;
        end
    end

    // Reference model: RX outcome per byte, TX as a timeline of frames with a one-slot queue.
    int tx_end    = -1000;
    bit pend      = 1'b0;
    int pend_data = 0;
    int model_cmd = 0;

    function automatic void model_capture(int p, int d);
        if (pend && tx_end < p) begin
            exp_fr.push_back(mk_fr(tx_end + 1, 256 + pend_data));
            tx_end = tx_end + FRAME;
            pend   = 1'b0;
        end
        if (p > tx_end) begin
            exp_fr.push_back(mk_fr(p + 1, 256 + d));
            tx_end = p + FRAME;
        end else begin
            pend      = 1'b1;
            pend_data = d;
        end
    endfunction

    function automatic void model_flush();
        if (pend) begin
            exp_fr.push_back(mk_fr(tx_end + 1, 256 + pend_data));
            tx_end = tx_end + FRAME;
            pend   = 1'b0;
        end
    endfunction

    function automatic void model_rx(int t_drive, logic [7:0] b, bit stop_ok, int det);
        int p;
        p = t_drive + RX_LAT;
        if (!stop_ok) begin
            exp_ev.push_back(mk_ev(p, 3, model_cmd));
        end else if (b[7:6] != 2'b10) begin
            exp_ev.push_back(mk_ev(p, 2, model_cmd));
        end else begin
            model_cmd = int'(b[5:0]);
            exp_ev.push_back(mk_ev(p, 1, model_cmd));
            model_capture(p, det);
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Called on a negedge; returns on a negedge FRAME (+extra_low) cycles later.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int extra_low,
                             input logic [3:0] det);
        detector_in = det;
        model_rx(cyc, b, stop_ok, int'(det));
        rxd = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(C);
        end
        rxd = stop_ok;
        idle(stop_ok ? C : C + extra_low);
        rxd = 1'b1;
    endtask

    task automatic compare_all(input string phase);
        int runs[$];
        int run;
        model_flush();
        while (cyc <= tx_end + 5) @(negedge sys_clk);
        idle(5);
        check({phase, "_event_count"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
            check($sformatf("%s_ev%0d_cycle", phase, i), obs_ev[i].t, exp_ev[i].t);
            check($sformatf("%s_ev%0d_kind", phase, i), obs_ev[i].kind, exp_ev[i].kind);
            check($sformatf("%s_ev%0d_cmd", phase, i), obs_ev[i].cmd, exp_ev[i].cmd);
        end
        check({phase, "_reply_count"}, obs_fr.size(), exp_fr.size());
        for (int i = 0; i < exp_fr.size() && i < obs_fr.size(); i++) begin
            check($sformatf("%s_reply%0d_start", phase, i), obs_fr[i].t, exp_fr[i].t);
            check($sformatf("%s_reply%0d_stop_data", phase, i), obs_fr[i].data, exp_fr[i].data);
        end
        if (exp_fr.size() > 0) begin
            run = FRAME;
            for (int i = 1; i < exp_fr.size(); i++) begin
                if (exp_fr[i].t == exp_fr[i-1].t + FRAME) begin
                    run += FRAME;
                end else begin
                    runs.push_back(run);
                    run = FRAME;
                end
            end
            runs.push_back(run);
        end
        check({phase, "_busy_run_count"}, obs_busy.size(), runs.size());
        for (int i = 0; i < runs.size() && i < obs_busy.size(); i++) begin
            check($sformatf("%s_busy_run%0d_len", phase, i), obs_busy[i], runs[i]);
        end
        obs_ev.delete(); exp_ev.delete();
        obs_fr.delete(); exp_fr.delete();
        obs_busy.delete();
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;
        int         lows;

        rxd         = 1'b1;
        detector_in = 4'h0;
        rst         = 1'b1;
        #1;
        check("reset_txd", txd, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_cmd", cmd, 0);
        check("reset_pulses", {cmd_valid, hdr_err, frame_err}, 0);
        idle(3);
        rst = 1'b0;
        idle(4);

        send_byte(8'h81, 1'b1, 0, 4'b0101);
        check("cmd_after_0x81", cmd, 6'b000001);
        send_byte(8'h4F, 1'b1, 0, 4'b1111);
        check("cmd_after_bad_header", cmd, 6'b000001);
        idle(3);
        send_byte(8'h82, 1'b0, 40, 4'b0011);
        check("cmd_after_frame_err", cmd, 6'b000001);
        idle(5);
        send_byte(8'h84, 1'b1, 0, 4'b1001);
        check("cmd_after_0x84", cmd, 6'b000100);
        send_byte(8'h82, 1'b1, 0, 4'h1);
        send_byte(8'h84, 1'b1, 0, 4'h2);
        send_byte(8'h88, 1'b1, 0, 4'h4);
        idle(10);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(20);
        send_byte(8'hA0, 1'b1, 0, 4'h6);
        check("cmd_after_glitch_0xA0", cmd, 6'b100000);
        compare_all("directed");

        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 9) < 6) b[7:6] = 2'b10;
            ok  = ($urandom_range(0, 7) != 0);
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
            idle(gap);
            send_byte(b, ok, int'($urandom_range(0, 30)), 4'($urandom));
            if (!ok) idle(2);
        end
        compare_all("random");

        send_byte(8'h81, 1'b1, 0, 4'hA);
        idle(40);
        check("busy_before_reset", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("midtx_reset_txd", txd, 1);
        check("midtx_reset_tx_busy", tx_busy, 0);
        check("midtx_reset_cmd", cmd, 0);
        idle(3);
        rst = 1'b0;
        obs_ev.delete(); exp_ev.delete();
        obs_fr.delete(); exp_fr.delete();
        obs_busy.delete();
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge sys_clk);
            if (txd !== 1'b1) lows++;
        end
        check("txd_idle_after_reset", lows, 0);
        check("no_pulses_after_reset", obs_ev.size(), 0);
        check("no_busy_after_reset", obs_busy.size() + busy_len, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
